// File: rtl/sauria_seq_pkg.sv
// Shared types for the SAURIA cfg-port command sequencer: opcodes,
// FSM states, command record and a saturating accumulate helper.
package sauria_seq_pkg;

    localparam int unsigned CFG_ADDR_W = 32;
    localparam int unsigned CFG_DATA_W = 32;

    typedef enum logic [2:0] {
        OP_WRITE    = 3'd0,
        OP_POLL     = 3'd1,
        OP_WAIT_IRQ = 3'd2,
        OP_CHECK    = 3'd3,
        OP_END      = 3'd4
    } opcode_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR,
        S_RD_ADDR,
        S_RD_DATA,
        S_POLL_WAIT,
        S_IRQ_WAIT,
        S_CHK_SETUP,
        S_CHK_HOLD,
        S_DONE
    } state_e;

    typedef struct packed {
        opcode_e                 op;
        logic [CFG_ADDR_W-1:0]   addr;
        logic [CFG_DATA_W-1:0]   data;
        logic [CFG_DATA_W-1:0]   mask;
    } cmd_t;

    // 32-bit add that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

endpackage

// File: rtl/sauria_seq_timer.sv
// Clearable up-counter with a terminal-count flag; reused for the poll
// gap, the check_flag hold and the command timeout.
module sauria_seq_timer #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] terminal,
    output logic         tc
);

    logic [W-1:0] count;

    // count up while enabled, held at zero whenever cleared
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = en && (count == terminal);

endmodule

// File: rtl/sauria_cfg_sequencer.sv
// Command-driven AXI4-Lite cfg master for the SAURIA bench: writes,
// polls, waits on interrupts, triggers DRAM checks and keeps a verdict.
module sauria_cfg_sequencer
    import sauria_seq_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned POLL_GAP    = 16,
    parameter int unsigned CHECK_HOLD  = 4
) (
    input  logic              i_system_clk,
    input  logic              i_system_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [2:0]        i_cmd_op,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_data,
    input  logic [DATA_W-1:0] i_cmd_mask,
    output logic [ADDR_W-1:0] o_ar_addr,
    output logic              o_ar_valid,
    input  logic              i_ar_ready,
    input  logic [DATA_W-1:0] i_r_data,
    input  logic              i_r_valid,
    output logic              o_r_ready,
    output logic [ADDR_W-1:0] o_aw_addr,
    output logic              o_aw_valid,
    input  logic              i_aw_ready,
    output logic [DATA_W-1:0] o_w_data,
    output logic              o_w_valid,
    input  logic              i_w_ready,
    input  logic              i_ctrl_irq,
    input  logic              i_sauria_irq,
    input  logic              i_dma_irq,
    output logic              o_check_flag,
    output logic [31:0]       o_dram_startoffs,
    output logic [31:0]       o_dram_outoffs,
    output logic [31:0]       o_dram_endoffs,
    input  logic [31:0]       i_errors,
    output logic [31:0]       o_err_total,
    output logic              o_timeout,
    output logic              o_done,
    output logic              o_pass
);

    localparam logic [31:0] TO_TERM   = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] GAP_TERM  = 32'(POLL_GAP - 1);
    localparam logic [31:0] HOLD_TERM = 32'(CHECK_HOLD - 1);

    state_e            state;
    cmd_t              cmd_in;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] mask_q;

    logic              to_clr, to_en, to_tc;
    logic              aux_clr, aux_en, aux_tc;
    logic [31:0]       aux_term;
    logic [2:0]        irq_sel;
    logic              irq_hit;
    logic              poll_match;

    assign cmd_in = '{op: opcode_e'(i_cmd_op), addr: i_cmd_addr, data: i_cmd_data, mask: i_cmd_mask};

    // addr/data registers double as the AXI address/data outputs and as
    // the poll compare value / irq select for the command in flight
    assign o_ar_addr = addr_q;
    assign o_aw_addr = addr_q;
    assign o_w_data  = data_q;

    assign o_cmd_ready = (state == S_IDLE);
    assign o_pass      = o_done && !o_timeout && (o_err_total == '0);

    assign irq_sel    = data_q[2:0];
    assign irq_hit    = |(irq_sel & {i_dma_irq, i_sauria_irq, i_ctrl_irq});
    assign poll_match = (((i_r_data ^ data_q) & mask_q) == '0);

    // timer enables follow the state: timeout spans the whole poll/irq wait,
    // the aux timer covers the poll gap and the check_flag hold
    always_comb begin
        to_en    = 1'b0;
        aux_en   = 1'b0;
        aux_term = HOLD_TERM;
        case (state)
            S_RD_ADDR, S_RD_DATA, S_IRQ_WAIT: to_en = 1'b1;
            S_POLL_WAIT: begin
                to_en    = 1'b1;
                aux_en   = 1'b1;
                aux_term = GAP_TERM;
            end
            S_CHK_HOLD: aux_en = 1'b1;
            default: ;
        endcase
        to_clr  = !to_en;
        aux_clr = !aux_en;
    end

    sauria_seq_timer #(.W(32)) u_timeout (
        .clk      (i_system_clk),
        .rst      (i_system_rst),
        .clr      (to_clr),
        .en       (to_en),
        .terminal (TO_TERM),
        .tc       (to_tc)
    );

    sauria_seq_timer #(.W(32)) u_aux (
        .clk      (i_system_clk),
        .rst      (i_system_rst),
        .clr      (aux_clr),
        .en       (aux_en),
        .terminal (aux_term),
        .tc       (aux_tc)
    );

    // command FSM with registered AXI, check and verdict outputs
    always_ff @(posedge i_system_clk) begin
        if (i_system_rst) begin
            state            <= S_IDLE;
            addr_q           <= '0;
            data_q           <= '0;
            mask_q           <= '0;
            o_ar_valid       <= 1'b0;
            o_r_ready        <= 1'b0;
            o_aw_valid       <= 1'b0;
            o_w_valid        <= 1'b0;
            o_check_flag     <= 1'b0;
            o_dram_startoffs <= '0;
            o_dram_outoffs   <= '0;
            o_dram_endoffs   <= '0;
            o_err_total      <= '0;
            o_timeout        <= 1'b0;
            o_done           <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        addr_q <= cmd_in.addr;
                        data_q <= cmd_in.data;
                        mask_q <= cmd_in.mask;
                        case (cmd_in.op)
                            OP_WRITE: begin
                                o_aw_valid <= 1'b1;
                                o_w_valid  <= 1'b1;
                                state      <= S_WR;
                            end
                            OP_POLL: begin
                                o_ar_valid <= 1'b1;
                                state      <= S_RD_ADDR;
                            end
                            OP_WAIT_IRQ: state <= S_IRQ_WAIT;
                            OP_CHECK: begin
                                o_dram_startoffs <= cmd_in.addr;
                                o_dram_endoffs   <= cmd_in.data;
                                o_dram_outoffs   <= cmd_in.mask;
                                state            <= S_CHK_SETUP;
                            end
                            default: begin
                                o_done <= 1'b1;
                                state  <= S_DONE;
                            end
                        endcase
                    end
                end
                S_WR: begin
                    if (i_aw_ready) o_aw_valid <= 1'b0;
                    if (i_w_ready)  o_w_valid  <= 1'b0;
                    if ((!o_aw_valid || i_aw_ready) && (!o_w_valid || i_w_ready)) begin
                        state <= S_IDLE;
                    end
                end
                S_RD_ADDR: begin
                    if (to_tc) begin
                        o_ar_valid <= 1'b0;
                        o_timeout  <= 1'b1;
                        o_done     <= 1'b1;
                        state      <= S_DONE;
                    end else if (i_ar_ready) begin
                        o_ar_valid <= 1'b0;
                        o_r_ready  <= 1'b1;
                        state      <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (to_tc) begin
                        o_r_ready <= 1'b0;
                        o_timeout <= 1'b1;
                        o_done    <= 1'b1;
                        state     <= S_DONE;
                    end else if (i_r_valid) begin
                        o_r_ready <= 1'b0;
                        state     <= poll_match ? S_IDLE : S_POLL_WAIT;
                    end
                end
                S_POLL_WAIT: begin
                    if (to_tc) begin
                        o_timeout <= 1'b1;
                        o_done    <= 1'b1;
                        state     <= S_DONE;
                    end else if (aux_tc) begin
                        o_ar_valid <= 1'b1;
                        state      <= S_RD_ADDR;
                    end
                end
                S_IRQ_WAIT: begin
                    if (to_tc) begin
                        o_timeout <= 1'b1;
                        o_done    <= 1'b1;
                        state     <= S_DONE;
                    end else if ((irq_sel == 3'b000) || irq_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_CHK_SETUP: begin
                    o_check_flag <= 1'b1;
                    state        <= S_CHK_HOLD;
                end
                S_CHK_HOLD: begin
                    if (aux_tc) begin
                        o_check_flag <= 1'b0;
                        o_err_total  <= sat_add32(o_err_total, i_errors);
                        state        <= S_IDLE;
                    end
                end
                S_DONE: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sauria_cfg_sequencer.sv
// Directed, table-driven bench for sauria_cfg_sequencer.
module tb_sauria_cfg_sequencer;
    import sauria_seq_pkg::*;

    localparam int unsigned TO   = 50;
    localparam int unsigned GAP  = 16;
    localparam int unsigned HOLD = 4;

    logic        clk;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_addr, cmd_data, cmd_mask;
    logic [31:0] ar_addr, r_data, aw_addr, w_data;
    logic        ar_valid, ar_ready, r_valid, r_ready;
    logic        aw_valid, aw_ready, w_valid, w_ready;
    logic        ctrl_irq, sauria_irq, dma_irq;
    logic        check_flag;
    logic [31:0] startoffs, outoffs, endoffs, errs_in, err_total;
    logic        timeout, done, pass;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sauria_cfg_sequencer #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO), .POLL_GAP(GAP), .CHECK_HOLD(HOLD)
    ) dut (
        .i_system_clk(clk), .i_system_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
        .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data), .i_cmd_mask(cmd_mask),
        .o_ar_addr(ar_addr), .o_ar_valid(ar_valid), .i_ar_ready(ar_ready),
        .i_r_data(r_data), .i_r_valid(r_valid), .o_r_ready(r_ready),
        .o_aw_addr(aw_addr), .o_aw_valid(aw_valid), .i_aw_ready(aw_ready),
        .o_w_data(w_data), .o_w_valid(w_valid), .i_w_ready(w_ready),
        .i_ctrl_irq(ctrl_irq), .i_sauria_irq(sauria_irq), .i_dma_irq(dma_irq),
        .o_check_flag(check_flag),
        .o_dram_startoffs(startoffs), .o_dram_outoffs(outoffs), .o_dram_endoffs(endoffs),
        .i_errors(errs_in), .o_err_total(err_total),
        .o_timeout(timeout), .o_done(done), .o_pass(pass)
    );

    // handshake monitor: inputs change 1ns after posedge, so the negedge
    // sees exactly what the next posedge will see
    int          cyc = 0;
    int          aw_hs = 0, w_hs = 0;
    logic [31:0] aw_addr_seen = '0, w_data_seen = '0;
    int          ar_cyc[$];
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst && aw_valid && aw_ready) begin aw_hs = aw_hs + 1; aw_addr_seen = aw_addr; end
        if (!rst && w_valid && w_ready)   begin w_hs = w_hs + 1;   w_data_seen = w_data;   end
        if (!rst && ar_valid && ar_ready) ar_cyc.push_back(cyc);
    end

    typedef struct {
        logic [2:0] sel;
        logic       c, s, d;
        logic       exit1;
    } irq_vec_t;

    typedef struct {
        logic [31:0] addr, data, mask, errs, exp_total;
    } chk_vec_t;

    irq_vec_t itab[8];
    chk_vec_t ctab[3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready(input string name, input int max);
        int n;
        n = 0;
        while (!cmd_ready && n < max) begin tick(); n++; end
        chk(name, {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic wait_ar(input string name, input int max);
        int n;
        n = 0;
        while (!ar_valid && n < max) begin tick(); n++; end
        chk(name, {31'd0, ar_valid}, 32'd1);
    endtask

    // returns with the command accepted on the last edge (DUT now in the new state)
    task automatic send_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] m);
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
        wait_ready("cmd_accept_wait", 200);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    // runs one CHECK, verifies offsets during setup and the flag hold length
    task automatic run_check(input string name, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] m, input logic [31:0] e);
        int hold;
        hold = 0;
        errs_in = e;
        send_cmd(3'(OP_CHECK), a, d, m);
        chk({name, "_startoffs"}, startoffs, a);
        chk({name, "_endoffs"}, endoffs, d);
        chk({name, "_outoffs"}, outoffs, m);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (check_flag) hold++;
            if (cmd_ready) break;
        end
        chk({name, "_flag_hold"}, 32'(hold), 32'(HOLD));
        chk({name, "_back_idle"}, {31'd0, cmd_ready}, 32'd1);
        errs_in = '0;
    endtask

    initial begin
        int b;

        itab[0] = '{sel: 3'b001, c: 1'b1, s: 1'b0, d: 1'b0, exit1: 1'b1};
        itab[1] = '{sel: 3'b001, c: 1'b0, s: 1'b1, d: 1'b1, exit1: 1'b0};
        itab[2] = '{sel: 3'b010, c: 1'b0, s: 1'b1, d: 1'b0, exit1: 1'b1};
        itab[3] = '{sel: 3'b100, c: 1'b1, s: 1'b1, d: 1'b0, exit1: 1'b0};
        itab[4] = '{sel: 3'b100, c: 1'b0, s: 1'b0, d: 1'b1, exit1: 1'b1};
        itab[5] = '{sel: 3'b000, c: 1'b0, s: 1'b0, d: 1'b0, exit1: 1'b1};
        itab[6] = '{sel: 3'b110, c: 1'b0, s: 1'b0, d: 1'b1, exit1: 1'b1};
        itab[7] = '{sel: 3'b011, c: 1'b0, s: 1'b0, d: 1'b0, exit1: 1'b0};

        ctab[0] = '{addr: 32'h200, data: 32'h2FF, mask: 32'h280, errs: 32'hFFFF_FFF0, exp_total: 32'hFFFF_FFF0};
        ctab[1] = '{addr: 32'h300, data: 32'h3FF, mask: 32'h380, errs: 32'h0000_0020, exp_total: 32'hFFFF_FFFF};
        ctab[2] = '{addr: 32'h000, data: 32'h001, mask: 32'h002, errs: 32'h0000_0005, exp_total: 32'hFFFF_FFFF};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; cmd_mask = '0;
        ar_ready = 1'b0; r_data = '0; r_valid = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
        ctrl_irq = 1'b0; sauria_irq = 1'b0; dma_irq = 1'b0; errs_in = '0;
        tick(); tick();
        rst = 1'b0;

        // ---- reset state
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_valids", {28'd0, ar_valid, aw_valid, w_valid, r_ready}, 32'd0);
        chk("rst_flags", {28'd0, check_flag, timeout, done, pass}, 32'd0);
        chk("rst_err_total", err_total, 32'd0);
        chk("rst_offsets", startoffs | outoffs | endoffs, 32'd0);

        // ---- WRITE: w_ready in cycle 1, aw_ready in cycle 3
        send_cmd(3'(OP_WRITE), 32'h10, 32'hA5A5_0001, 32'h0);
        chk("wr_valids_rise", {30'd0, aw_valid, w_valid}, 32'd3);
        w_ready = 1'b1;
        tick();
        w_ready = 1'b0;
        chk("wr_after_w", {29'd0, aw_valid, w_valid, cmd_ready}, 32'b100);
        tick();
        chk("wr_aw_held", {31'd0, aw_valid}, 32'd1);
        aw_ready = 1'b1;
        tick();
        aw_ready = 1'b0;
        chk("wr_ready_back", {29'd0, aw_valid, w_valid, cmd_ready}, 32'b001);
        tick(); tick();
        chk("wr_aw_count", 32'(aw_hs), 32'd1);
        chk("wr_w_count", 32'(w_hs), 32'd1);
        chk("wr_aw_addr", aw_addr_seen, 32'h10);
        chk("wr_w_data", w_data_seen, 32'hA5A5_0001);

        // ---- POLL: slave returns 0, 0, then 1
        b = ar_cyc.size();
        ar_ready = 1'b1; r_valid = 1'b1;
        send_cmd(3'(OP_POLL), 32'h0, 32'h1, 32'h1);
        for (int k = 0; k < 3; k++) begin
            wait_ar("poll_ar_wait", 40);
            r_data = (k == 2) ? 32'h1 : 32'h0;
            tick();
        end
        wait_ready("poll_idle_wait", 10);
        ar_ready = 1'b0; r_valid = 1'b0; r_data = '0;
        tick(); tick();
        chk("poll_ar_count", 32'(ar_cyc.size() - b), 32'd3);
        if (ar_cyc.size() - b == 3) begin
            chk("poll_gap1", 32'(ar_cyc[b+1] - ar_cyc[b] >= GAP), 32'd1);
            chk("poll_gap2", 32'(ar_cyc[b+2] - ar_cyc[b+1] >= GAP), 32'd1);
        end
        chk("poll_no_timeout", {30'd0, timeout, r_ready}, 32'd0);

        // ---- WAIT_IRQ table: exit exactly one cycle after entry or not
        for (int i = 0; i < 8; i++) begin
            ctrl_irq = itab[i].c; sauria_irq = itab[i].s; dma_irq = itab[i].d;
            send_cmd(3'(OP_WAIT_IRQ), 32'h0, {29'd0, itab[i].sel}, 32'h0);
            tick();
            chk($sformatf("irq_vec%0d_exit", i), {31'd0, cmd_ready}, {31'd0, itab[i].exit1});
            ctrl_irq = 1'b1; sauria_irq = 1'b1; dma_irq = 1'b1;
            wait_ready($sformatf("irq_vec%0d_release", i), 5);
            ctrl_irq = 1'b0; sauria_irq = 1'b0; dma_irq = 1'b0;
        end
        chk("irq_no_timeout", {31'd0, timeout}, 32'd0);

        // ---- two CHECKs then END
        run_check("chkA", 32'h100, 32'h1FF, 32'h180, 32'd3);
        chk("chkA_total", err_total, 32'd3);
        run_check("chkB", 32'h400, 32'h4FF, 32'h480, 32'd0);
        chk("chkB_total", err_total, 32'd3);
        chk("chk_offs_hold", startoffs, 32'h400);
        send_cmd(3'(OP_END), '0, '0, '0);
        chk("end_done", {31'd0, done}, 32'd1);
        chk("end_pass", {31'd0, pass}, 32'd0);
        tick(); tick();
        chk("end_ready_low", {31'd0, cmd_ready}, 32'd0);

        // ---- saturating accumulation table
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_check($sformatf("sat%0d", i), ctab[i].addr, ctab[i].data, ctab[i].mask, ctab[i].errs);
            chk($sformatf("sat%0d_total", i), err_total, ctab[i].exp_total);
        end

        // ---- reset while AR is pending in POLL
        ar_ready = 1'b0;
        send_cmd(3'(OP_POLL), 32'h44, 32'h1, 32'h1);
        tick();
        chk("rstpoll_ar_held", {31'd0, ar_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstpoll_valids", {28'd0, ar_valid, aw_valid, w_valid, r_ready}, 32'd0);
        chk("rstpoll_idle", {31'd0, cmd_ready}, 32'd1);
        chk("rstpoll_err_total", err_total, 32'd0);

        // ---- full passing sequence
        aw_ready = 1'b1; w_ready = 1'b1;
        send_cmd(3'(OP_WRITE), 32'h20, 32'h0000_0001, 32'h0);
        wait_ready("full_wr", 5);
        aw_ready = 1'b0; w_ready = 1'b0;
        sauria_irq = 1'b1;
        send_cmd(3'(OP_WAIT_IRQ), 32'h0, 32'b010, 32'h0);
        wait_ready("full_irq", 5);
        sauria_irq = 1'b0;
        run_check("full_chk", 32'h800, 32'h8FF, 32'h880, 32'd0);
        chk("full_pass_before_end", {31'd0, pass}, 32'd0);
        send_cmd(3'(OP_END), '0, '0, '0);
        chk("full_pass", {29'd0, done, timeout, pass}, 32'b101);

        // ---- WAIT_IRQ on dma only, ctrl high is ignored -> timeout
        do_reset();
        ctrl_irq = 1'b1;
        send_cmd(3'(OP_WAIT_IRQ), 32'h0, 32'b100, 32'h0);
        for (int n = 1; n < TO; n++) tick();
        chk("to_not_yet", {30'd0, timeout, cmd_ready}, 32'd0);
        tick();
        chk("to_fired", {29'd0, timeout, done, pass}, 32'b110);
        chk("to_ready_low", {31'd0, cmd_ready}, 32'd0);
        ctrl_irq = 1'b0;

        // ---- undefined opcode behaves like END
        do_reset();
        send_cmd(3'd6, '0, '0, '0);
        chk("undef_done", {29'd0, done, timeout, cmd_ready}, 32'b100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // hard stop in case a wait loop is broken
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/sauria_cfg_sequencer.md
Name: sauria_cfg_sequencer

Overview:
- Command-driven stimulus master in front of the SAURIA subsystem bench: plays a stream of configuration commands onto the 32-bit AXI4-Lite cfg port, polls status registers, waits on interrupts and triggers the DRAM result check.
- Owns every cfg_bus_lite_* input, check_flag and the dram_*offs offsets of the tester.
- Consumes the tester's `errors` and interrupts.
- Accumulates a pass/fail verdict.

Parameters:
- ADDR_W, 32, AXI-Lite address width
- DATA_W, 32, AXI-Lite data width
- TIMEOUT_CYC, 1000000, max cycles spent in any POLL or WAIT_IRQ command
- POLL_GAP, 16, idle cycles between consecutive poll reads
- CHECK_HOLD, 4, cycles check_flag is held high

Ports:
- i_system_clk  in  1  system clock
- i_system_rst  in  1  synchronous active-high reset
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command accepted
- i_cmd_op  in  3  opcode, see package
- i_cmd_addr  in  ADDR_W  register address / check start offset
- i_cmd_data  in  DATA_W  write data / poll expected value / irq select / check end offset
- i_cmd_mask  in  DATA_W  poll mask / check output offset
- o_ar_addr  out  ADDR_W; o_ar_valid out 1; i_ar_ready in 1
- i_r_data  in  DATA_W; i_r_valid in 1; o_r_ready out 1
- o_aw_addr  out  ADDR_W; o_aw_valid out 1; i_aw_ready in 1
- o_w_data  out  DATA_W; o_w_valid out 1; i_w_ready in 1
- i_ctrl_irq, i_sauria_irq, i_dma_irq  in  1 each  interrupt levels
- o_check_flag  out  1  check trigger
- o_dram_startoffs, o_dram_outoffs, o_dram_endoffs  out  32 each
- i_errors  in  32  mismatch count returned by checker
- o_err_total  out  32  saturating sum of all i_errors samples
- o_timeout  out  1  sticky timeout flag
- o_done  out  1  sticky, END executed or timeout
- o_pass  out  1  o_done & ~o_timeout & (o_err_total==0)

Behaviour:
- Reset (synchronous, i_system_rst=1 at clock edge):
  - All valids, o_check_flag, o_done, o_timeout, o_pass = 0.
  - All offsets, addr/data, o_err_total = 0.
  - o_r_ready = 0.
  - State goes to IDLE.
  - Reset mid-transaction drops valids immediately; no completion is required.
- IDLE: o_cmd_ready=1. A command is accepted on valid&ready and its fields are registered. Next state is decoded by opcode. o_cmd_ready=0 in every other state.
- OP_WRITE (0) -> WR:
  - o_aw_valid and o_w_valid rise together the cycle after accept.
  - Each valid drops independently on its own ready.
  - Both accepted (same or different cycles) -> IDLE.
  - Valids are never withdrawn before handshake and addr/data stay stable. No B channel (bready tied high downstream).
- OP_POLL (1):
  - RD_ADDR: o_ar_valid=1 until i_ar_ready.
  - RD_DATA: o_r_ready=1. On i_r_valid, if (i_r_data & mask)==(data & mask) -> IDLE, else -> POLL_WAIT.
  - POLL_WAIT counts POLL_GAP cycles, then -> RD_ADDR.
- OP_WAIT_IRQ (2) -> IRQ_WAIT:
  - data[0]/[1]/[2] select ctrl/sauria/dma.
  - Exit to IDLE the first cycle any selected irq is high.
  - data[2:0]==0 exits the next cycle.
- Timeout:
  - A 32-bit timer clears on entry to POLL or IRQ_WAIT and increments each cycle in those states.
  - Reaching TIMEOUT_CYC takes priority over completion in the same cycle: o_timeout=1, valids drop, -> DONE.
- OP_CHECK (3):
  - CHK_SETUP (1 cycle): startoffs=addr, endoffs=data, outoffs=mask driven.
  - CHK_HOLD: o_check_flag=1 for CHECK_HOLD cycles.
  - On the last hold cycle i_errors is sampled and added to o_err_total, saturating at 0xFFFFFFFF.
  - check_flag then drops -> IDLE.
  - Offsets hold until the next CHECK.
- OP_END (4) and any undefined opcode -> DONE: o_done=1, o_cmd_ready=0 until reset.
- Throughput: one command per state exit; the earliest next accept is the cycle after return to IDLE.

Decomposition:
- Shared package sauria_seq_pkg:
  - opcode enum (OP_WRITE, OP_POLL, OP_WAIT_IRQ, OP_CHECK, OP_END)
  - state enum
  - cmd_t struct (op, addr, data, mask)
- One natural sub-module, sauria_seq_timer: loadable counter with terminal-count flag, reused for POLL_GAP, CHECK_HOLD and the timeout.

Test Plan:
- WRITE addr 0x10 data 0xA5A5_0001; aw_ready at cycle 3, w_ready at cycle 1 → exactly one handshake each with correct values; o_cmd_ready back high 1 cycle after the later handshake.
- POLL addr 0x0 mask 0x1 data 0x1; slave returns 0, 0, then 1 → exactly 3 AR handshakes ≥POLL_GAP=16 apart, then IDLE, o_timeout=0.
- WAIT_IRQ data 0b100 with TIMEOUT_CYC=50 and dma_irq never rising; ctrl_irq high is ignored → o_timeout=1, o_done=1, o_pass=0 at cycle 50 after entry.
- CHECK addr 0x100 data 0x1FF mask 0x180, i_errors=3, then second CHECK with i_errors=0 → offsets match; check_flag high exactly 4 cycles per check; o_err_total=3; END → o_done=1, o_pass=0.
- Reset asserted while o_ar_valid=1 in POLL → next cycle all valids 0, state IDLE, o_err_total=0.
- Full sequence (WRITE, WAIT_IRQ sauria, CHECK with i_errors=0, END) → o_pass=1.
